// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin grant,
// whole-burst ownership and a watchdog that turns a hung slave into ERR.
module wb_rr_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    input  logic [DW/8-1:0] m0_sel,
    output logic [DW-1:0]   m0_dat_r,
    output logic            m0_ack,
    output logic            m0_err,

    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    input  logic [DW/8-1:0] m1_sel,
    output logic [DW-1:0]   m1_dat_r,
    output logic            m1_ack,
    output logic            m1_err,

    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [DW/8-1:0] s_sel,
    input  logic [DW-1:0]   s_dat_r,
    input  logic            s_ack,
    input  logic            s_err,

    output logic [1:0]      grant
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic            last_nxt;
    logic [WW-1:0]   wdog;
    logic [WW-1:0]   wdog_nxt;
    logic [1:0]      grant_nxt;
    logic            own0;
    logic            own1;
    logic            wdog_fire;

    // Ownership is masked by reset so nothing reaches either side while reset is held.
    assign own0 = reset && (state == OWN0);
    assign own1 = reset && (state == OWN1);

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        if (own0) begin
            s_cyc   = m0_cyc;
            s_stb   = m0_stb;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_dat_w = m0_dat_w;
            s_sel   = m0_sel;
        end else if (own1) begin
            s_cyc   = m1_cyc;
            s_stb   = m1_stb;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_dat_w = m1_dat_w;
            s_sel   = m1_sel;
        end
    end

    // A slave ACK in the firing cycle takes precedence over the forced error.
    assign wdog_fire = s_stb && !s_ack && (wdog == WW'(TIMEOUT));

    assign m0_ack   = s_ack && own0;
    assign m1_ack   = s_ack && own1;
    assign m0_err   = (s_err || wdog_fire) && own0;
    assign m1_err   = (s_err || wdog_fire) && own1;
    assign m0_dat_r = own0 ? s_dat_r : '0;
    assign m1_dat_r = own1 ? s_dat_r : '0;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (m0_cyc) begin
                    state_nxt = OWN0;
                end else if (m1_cyc) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc || wdog_fire) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc || wdog_fire) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        grant_nxt = {state_nxt == OWN1, state_nxt == OWN0};
    end

    always_comb begin
        wdog_nxt = wdog + WW'(1);
        if (!s_stb || s_ack || s_err || wdog_fire) begin
            wdog_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= '0;
            grant <= 2'b00;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
            grant <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (watchdog shortened to 4 cycles).
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_w;
    logic [3:0]  m0_sel;
    logic [31:0] m0_dat_r;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_w;
    logic [3:0]  m1_sel;
    logic [31:0] m1_dat_r;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_ack, s_err;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    wb_rr_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
        s_dat_r = '0; s_ack = 0; s_err = 0;
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task do_reset();
        idle_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
        #1;
    endtask

    task test_reset();
        do_reset();
        reset = 0; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_grant: got %b want 00", grant); end
            n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_s_cyc: got %b want 0", s_cyc); end
        end
        reset = 1;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("[TB] FAIL rst_release_grant: got %b want 01", grant); end
        n_cmp++; if (s_cyc !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_release_s_cyc: got %b want 1", s_cyc); end
        s_ack = 1; #1;
        n_cmp++; if (m0_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL midburst_ack: got %b want 1", m0_ack); end
        reset = 0; #1;
        n_cmp++; if ({m0_ack, m1_ack, s_cyc} !== 3'b000) begin n_bad++; $display("[TB] FAIL midburst_rst_out: got %b want 000", {m0_ack, m1_ack, s_cyc}); end
        step();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL midburst_rst_grant: got %b want 00", grant); end
        reset = 1;
    endtask

    task test_write();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h50; m0_dat_w = 32'h4140; m0_sel = 4'hF;
        m1_adr = 32'h99; m1_dat_w = 32'h7777; m1_sel = 4'h3;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("[TB] FAIL wr_grant: got %b want 01", grant); end
        n_cmp++; if (s_adr !== 32'h50) begin n_bad++; $display("[TB] FAIL wr_s_adr: got %h want 50", s_adr); end
        n_cmp++; if (s_dat_w !== 32'h4140) begin n_bad++; $display("[TB] FAIL wr_s_dat_w: got %h want 4140", s_dat_w); end
        n_cmp++; if ({s_we, s_sel, s_stb} !== 6'b1_1111_1) begin n_bad++; $display("[TB] FAIL wr_we_sel_stb: got %b want 111111", {s_we, s_sel, s_stb}); end
        n_cmp++; if (m0_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_early_ack: got %b want 0", m0_ack); end
        step();
        n_cmp++; if (m0_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_wait_ack: got %b want 0", m0_ack); end
        step();
        s_ack = 1; #1;
        n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_bad++; $display("[TB] FAIL wr_ack: got %b want 10", {m0_ack, m1_ack}); end
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0; #1;
        n_cmp++; if ({m0_ack, s_cyc} !== 2'b00) begin n_bad++; $display("[TB] FAIL wr_after_ack: got %b want 00", {m0_ack, s_cyc}); end
        step();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL wr_idle_grant: got %b want 00", grant); end
        n_cmp++; if (s_adr !== 32'h0) begin n_bad++; $display("[TB] FAIL wr_idle_s_adr: got %h want 0", s_adr); end
    endtask

    task test_round_robin();
        logic [1:0] cyc_tab [5];
        logic [1:0] exp_tab [5];
        cyc_tab = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
        exp_tab = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        do_reset();
        s_ack = 1;
        for (int k = 0; k < 5; k++) begin
            m0_cyc = cyc_tab[k][0]; m0_stb = cyc_tab[k][0];
            m1_cyc = cyc_tab[k][1]; m1_stb = cyc_tab[k][1];
            step();
            n_cmp++; if (grant !== exp_tab[k]) begin n_bad++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, grant, exp_tab[k]); end
            n_cmp++; if ({m1_ack, m0_ack} !== exp_tab[k]) begin n_bad++; $display("[TB] FAIL rr_ack[%0d]: got %b want %b", k, {m1_ack, m0_ack}, exp_tab[k]); end
        end
    endtask

    task test_no_preempt();
        do_reset();
        s_ack = 1;
        m1_cyc = 1; m1_stb = 1;
        step();
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("[TB] FAIL np_first_grant: got %b want 10", grant); end
        m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("[TB] FAIL np_hold[%0d]: got %b want 10", i, grant); end
            n_cmp++; if ({m1_ack, m0_ack} !== 2'b10) begin n_bad++; $display("[TB] FAIL np_ack[%0d]: got %b want 10", i, {m1_ack, m0_ack}); end
        end
        m1_cyc = 0; m1_stb = 0;
        step();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL np_dead_cycle: got %b want 00", grant); end
        step();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("[TB] FAIL np_m0_grant: got %b want 01", grant); end
        n_cmp++; if (m0_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL np_m0_ack: got %b want 1", m0_ack); end
    endtask

    task test_watchdog();
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++; if (m0_err !== (i == 5)) begin n_bad++; $display("[TB] FAIL wd_err[%0d]: got %b want %b", i, m0_err, (i == 5)); end
            n_cmp++; if (m1_err !== 1'b0) begin n_bad++; $display("[TB] FAIL wd_m1_err[%0d]: got %b want 0", i, m1_err); end
        end
        step();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL wd_idle_grant: got %b want 00", grant); end
        n_cmp++; if (m0_err !== 1'b0) begin n_bad++; $display("[TB] FAIL wd_idle_err: got %b want 0", m0_err); end
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) begin s_ack = 1; #1; end
            n_cmp++; if (m0_err !== 1'b0) begin n_bad++; $display("[TB] FAIL wd_ackwins_err[%0d]: got %b want 0", i, m0_err); end
        end
        n_cmp++; if (m0_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL wd_ackwins_ack: got %b want 1", m0_ack); end
        step();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("[TB] FAIL wd_ackwins_grant: got %b want 01", grant); end
    endtask

    task test_read();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h10;
        s_dat_r = 32'hDEADBEEF; #1;
        n_cmp++; if (m0_dat_r !== 32'h0) begin n_bad++; $display("[TB] FAIL rd_idle_dat: got %h want 0", m0_dat_r); end
        step();
        s_ack = 1; #1;
        n_cmp++; if (m0_dat_r !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL rd_m0_dat: got %h want deadbeef", m0_dat_r); end
        n_cmp++; if (m1_dat_r !== 32'h0) begin n_bad++; $display("[TB] FAIL rd_m1_dat: got %h want 0", m1_dat_r); end
        n_cmp++; if ({m0_ack, s_we} !== 2'b10) begin n_bad++; $display("[TB] FAIL rd_ack_we: got %b want 10", {m0_ack, s_we}); end
        step();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1; s_dat_r = 32'h12345678;
        step();
        n_cmp++; if ({grant, m1_dat_r} !== {2'b00, 32'h0}) begin n_bad++; $display("[TB] FAIL rd_gap: got %b/%h want 00/0", grant, m1_dat_r); end
        step();
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("[TB] FAIL rd_m1_grant: got %b want 10", grant); end
        n_cmp++; if ({m1_dat_r, m0_dat_r} !== {32'h12345678, 32'h0}) begin n_bad++; $display("[TB] FAIL rd_m1_dat_r: got %h/%h want 12345678/0", m1_dat_r, m0_dat_r); end
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_write();
        test_round_robin();
        test_no_preempt();
        test_watchdog();
        test_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL sim_timeout: got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
